// File: rtl/cg_phase_sequencer.sv
// cg_phase_sequencer: phase sequencer for an iterative CG solve.
// Alternates the matrix-vector and vector-vector units through
// INIT -> (MXV_RUN -> VXV_FLUSH -> VXV_RUN -> CHECK)* -> DONE.
// Optional macro SEQ_WATCHDOG_EN adds a per-phase watchdog that
// forces DONE with error=1 after TIMEOUT cycles without a done pulse.
module cg_phase_sequencer #(
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned VXV_HOLD = 2,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              reset_cluster,
  input  logic              vxv_done,
  input  logic              converged,
  output logic              reset_mXv1,
  output logic              reset_vXv1,
  output logic              halt,
  output logic              error,
  output logic              busy,
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned INIT_LEN = 2;
  localparam int unsigned PH_MAX   = (VXV_HOLD > INIT_LEN) ? VXV_HOLD : INIT_LEN;
  localparam int unsigned PH_W     = $clog2(PH_MAX) + 1;
  localparam logic [PH_W-1:0]   INIT_LAST  = PH_W'(INIT_LEN - 1);
  localparam logic [PH_W-1:0]   FLUSH_LAST = PH_W'(VXV_HOLD - 1);
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_SAT   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_MXV_RUN, S_VXV_FLUSH, S_VXV_RUN, S_CHECK, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PH_W-1:0]   ph_cnt, ph_cnt_nxt;
  logic [ITER_W-1:0] iter_nxt, iter_inc;
  logic              error_nxt;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic            wd_fire;

  assign wd_fire = (wd_cnt == WD_LAST);
`endif

  // Saturating iteration increment used by CHECK
  assign iter_inc = (iter_count == ITER_SAT) ? iter_count : iter_count + ITER_W'(1);

  // State and phase/iteration counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ph_cnt     <= '0;
      iter_count <= '0;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      ph_cnt     <= ph_cnt_nxt;
      iter_count <= iter_nxt;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt     <= wd_cnt_nxt;
`endif
    end
  end

  // Next-state, counter and sticky-error logic
  always_comb begin
    state_nxt  = state;
    ph_cnt_nxt = '0;
    iter_nxt   = iter_count;
    error_nxt  = error;
`ifdef SEQ_WATCHDOG_EN
    wd_cnt_nxt = '0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_INIT;
          iter_nxt  = '0;
        end
      end
      S_INIT: begin
        if (ph_cnt == INIT_LAST) state_nxt = S_MXV_RUN;
        else                     ph_cnt_nxt = ph_cnt + PH_W'(1);
      end
      S_MXV_RUN: begin
        // reset_cluster wins; a coincident vxv_done is dropped
        if (reset_cluster) state_nxt = S_VXV_FLUSH;
`ifdef SEQ_WATCHDOG_EN
        else if (wd_fire) begin
          state_nxt = S_DONE;
          error_nxt = 1'b1;
        end else wd_cnt_nxt = wd_cnt + WD_W'(1);
`endif
      end
      S_VXV_FLUSH: begin
        if (ph_cnt == FLUSH_LAST) state_nxt = S_VXV_RUN;
        else                      ph_cnt_nxt = ph_cnt + PH_W'(1);
      end
      S_VXV_RUN: begin
        if (vxv_done) state_nxt = S_CHECK;
`ifdef SEQ_WATCHDOG_EN
        else if (wd_fire) begin
          state_nxt = S_DONE;
          error_nxt = 1'b1;
        end else wd_cnt_nxt = wd_cnt + WD_W'(1);
`endif
      end
      S_CHECK: begin
        iter_nxt = iter_inc;
        if (converged || (iter_inc == ITER_LIMIT)) state_nxt = S_DONE;
        else                                       state_nxt = S_MXV_RUN;
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_INIT;
          iter_nxt  = '0;
          error_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state so they align with state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reset_mXv1 <= 1'b1;
      reset_vXv1 <= 1'b1;
      halt       <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      reset_mXv1 <= (state_nxt != S_MXV_RUN);
      reset_vXv1 <= (state_nxt != S_VXV_RUN);
      halt       <= (state_nxt == S_DONE);
      error      <= error_nxt;
      busy       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
    end
  end

endmodule

// File: doc/cg_phase_sequencer.md
CG_PHASE_SEQUENCER -- requirements
Module: cg_phase_sequencer

Interface
REQ-001 SHALL provide parameter MAX_ITER, default 64: iteration limit before forced halt.
REQ-002 SHALL provide parameter ITER_W, default 8: width of the iteration counter.
REQ-003 SHALL provide parameter VXV_HOLD, default 2: cycles reset_vXv1 is held high between phases.
REQ-004 SHALL provide parameter TIMEOUT, default 4096: per-phase watchdog limit in cycles.
REQ-005 SHALL provide port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL provide port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL provide port start, input, 1: begin a solve; sampled in IDLE and DONE only.
REQ-008 SHALL provide port reset_cluster, input, 1: matrix-vector cluster done pulse.
REQ-009 SHALL provide port vxv_done, input, 1: vector-vector unit done pulse.
REQ-010 SHALL provide port converged, input, 1: residual-below-threshold flag.
REQ-011 SHALL provide port reset_mXv1, output, 1: active-high hold of the matrix-vector unit.
REQ-012 SHALL provide port reset_vXv1, output, 1: active-high hold of the vector-vector unit.
REQ-013 SHALL provide port halt, output, 1: solve finished, sticky.
REQ-014 SHALL provide port error, output, 1: watchdog expiry, sticky with halt.
REQ-015 SHALL provide port busy, output, 1: high in every state except IDLE and DONE.
REQ-016 SHALL provide port iter_count, output, ITER_W: completed iterations.

Function
REQ-017 SHALL implement states IDLE, INIT, MXV_RUN, VXV_FLUSH, VXV_RUN, CHECK, DONE; all outputs SHALL be registered.
REQ-018 IDLE: reset_mXv1=1, reset_vXv1=1; start=1 -> INIT next cycle, iter_count cleared to 0.
REQ-019 INIT SHALL last exactly 2 cycles with both holds high, then -> MXV_RUN.
REQ-020 MXV_RUN: reset_mXv1=0, reset_vXv1=1; reset_cluster=1 -> VXV_FLUSH.
REQ-021 VXV_FLUSH SHALL last exactly VXV_HOLD cycles with both holds high, then -> VXV_RUN.
REQ-022 VXV_RUN: reset_mXv1=1, reset_vXv1=0; vxv_done=1 -> CHECK.
REQ-023 CHECK SHALL last 1 cycle, increment iter_count (saturating at 2^ITER_W-1), and go -> DONE if converged=1 or incremented count == MAX_ITER, else -> MXV_RUN.
REQ-024 DONE: halt=1, both holds high; start=1 -> INIT with halt, error, iter_count cleared.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 done pulses arriving in states that do not wait on them SHALL be ignored and not remembered.
REQ-027 reset_cluster and vxv_done high together in MXV_RUN SHALL advance only to VXV_FLUSH.
REQ-028 converged SHALL be sampled only in CHECK.
REQ-029 MAX_ITER=1 SHALL give exactly one MXV/VXV pass before DONE.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, reset_mXv1=1, reset_vXv1=1, halt=0, error=0, busy=0, iter_count=0, watchdog=0, in any state including mid-phase.
REQ-031 Deassertion SHALL take effect at the next clk edge; no pulse SHALL be lost on the first post-reset cycle.

Configuration
REQ-032 Macro SEQ_WATCHDOG_EN defined: a counter SHALL clear on each entry to MXV_RUN/VXV_RUN; if TIMEOUT cycles elapse without the awaited done pulse, go -> DONE with halt=1, error=1.
REQ-033 SEQ_WATCHDOG_EN undefined: no watchdog logic; error SHALL be constant 0 and states SHALL wait indefinitely.

Verification
REQ-034 Reset released, start pulse, reset_cluster 5 cycles into MXV_RUN, vxv_done 3 cycles into VXV_RUN, converged=1 at first CHECK -> halt=1, iter_count=1, error=0.
REQ-035 MAX_ITER=3, converged held 0 -> exactly 3 reset_mXv1 low windows, halt=1, iter_count=3.
REQ-036 VXV_HOLD=2: reset_vXv1 high for exactly 2 cycles between reset_cluster and VXV_RUN entry; reset_mXv1 rises the cycle after reset_cluster.
REQ-037 reset=0 asserted mid VXV_RUN at iter_count=2 -> same-cycle return to IDLE, both holds 1, iter_count=0; restart completes normally.
REQ-038 SEQ_WATCHDOG_EN, TIMEOUT=16, reset_cluster never pulsed -> halt=1, error=1 after 16 cycles in MXV_RUN; macro undefined -> busy stays 1, error 0.
REQ-039 start pulsed while busy, and vxv_done pulsed during MXV_RUN -> no state change from either.
